dac_frame_scheduler: RTL and testbench

- Sequences the serial DAC shifter at a fixed audio sample rate and shares it among NUM_CH sound channels.
- Each sample period, visits channels 0..NUM_CH-1 in fixed order.
- Per channel: fetches one 12-bit sample from that channel's valid/ready port, issues a load pulse, then holds shift-enable for exactly one frame.
- Sits between the sound mixers/voices and the DAC shifter; it drives the shifter's load, en, total_sound and address inputs.

---
 rtl/dac_pkg.sv | 20 ++
 rtl/dac_frame_scheduler_if.sv | 28 ++
 rtl/sample_tick_gen.sv | 27 ++
 rtl/dac_frame_scheduler.sv | 148 ++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC frame scheduler.
package dac_pkg;

  localparam int unsigned SAMPLE_W       = 12;
  localparam int unsigned ADDR_W         = 4;
  localparam int unsigned CMD_W          = 4;
  localparam int unsigned FRAME_OVERHEAD = 3;

  localparam logic [CMD_W-1:0]    DEFAULT_CMD = 4'b0011;
  localparam logic [SAMPLE_W-1:0] MUTE_LEVEL  = 12'h800;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StGap
  } state_e;

endpackage

// File: rtl/dac_frame_scheduler_if.sv
// Channel sample ports and DAC shifter controls of the frame scheduler.
interface dac_frame_scheduler_if
  import dac_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
);

  logic [NUM_CH-1:0]          ch_valid;
  logic [SAMPLE_W*NUM_CH-1:0] ch_sample;
  logic [NUM_CH-1:0]          ch_ready;
  logic                       dac_load;
  logic                       dac_en;
  logic [SAMPLE_W-1:0]        dac_word;
  logic [ADDR_W-1:0]          dac_addr;
  logic [CMD_W-1:0]           dac_cmd;
  logic                       dac_cs_n;

  modport master (
    input  ch_valid, ch_sample,
    output ch_ready, dac_load, dac_en, dac_word, dac_addr, dac_cmd, dac_cs_n
  );

  modport slave (
    output ch_valid, ch_sample,
    input  ch_ready, dac_load, dac_en, dac_word, dac_addr, dac_cmd, dac_cs_n
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every CLK_DIV enabled cycles, held at zero when disabled.
module sample_tick_gen #(
  parameter int unsigned CLK_DIV = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] count_q, count_d;

  assign tick = enable && (count_q == CntW'(CLK_DIV - 1));

  always_comb begin
    count_d = '0;
    if (enable && !tick) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Shares one serial DAC shifter among NUM_CH channels, one frame per channel per sample period.
// Build option DAC_MUTE_ON_UNDERRUN_EN: an underrun presents mid-scale instead of the last sample.
module dac_frame_scheduler
  import dac_pkg::*;
#(
  parameter int unsigned      NUM_CH     = 4,
  parameter int unsigned      CLK_DIV    = 1250,
  parameter int unsigned      FRAME_BITS = 32,
  parameter logic [CMD_W-1:0] CMD        = DEFAULT_CMD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr_flags,
  dac_frame_scheduler_if.master bus,
  output logic                  busy,
  output logic [NUM_CH-1:0]     underrun,
  output logic                  overrun
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CH - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(FRAME_BITS - 1);

  logic tick;

  sample_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  logic [SAMPLE_W-1:0] samples [NUM_CH];
  logic [SAMPLE_W-1:0] held_q  [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign samples[i] = bus.ch_sample[i*SAMPLE_W +: SAMPLE_W];
  end

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic [BitW-1:0]     bit_q;
  logic                load_q, en_q, cs_n_q, busy_q, overrun_q;
  logic [SAMPLE_W-1:0] word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_CH-1:0]   underrun_q;

  logic                cur_valid;
  logic [SAMPLE_W-1:0] fetch_word;

  always_comb begin
    cur_valid = bus.ch_valid[idx_q];
`ifdef DAC_MUTE_ON_UNDERRUN_EN
    fetch_word = MUTE_LEVEL;
`else
    fetch_word = held_q[idx_q];
`endif
    if (cur_valid) fetch_word = samples[idx_q];
  end

  // Ready is qualified by valid so the handshake completes within the single FETCH cycle.
  always_comb begin
    bus.ch_ready = '0;
    if (state_q == StFetch && cur_valid) bus.ch_ready[idx_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      bit_q      <= '0;
      load_q     <= 1'b0;
      en_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      word_q     <= '0;
      addr_q     <= '0;
      underrun_q <= '0;
      overrun_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) held_q[i] <= '0;
    end else begin
      // Clear first so a same-cycle flag event below takes precedence.
      if (clr_flags) begin
        underrun_q <= '0;
        overrun_q  <= 1'b0;
      end
      if (tick && state_q != StIdle) overrun_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (tick) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          if (!cur_valid) underrun_q[idx_q] <= 1'b1;
          held_q[idx_q] <= fetch_word;
          word_q        <= fetch_word;
          addr_q        <= ADDR_W'(idx_q);
          load_q        <= 1'b1;
          cs_n_q        <= 1'b0;
          state_q       <= StLoad;
        end
        StLoad: begin
          load_q  <= 1'b0;
          en_q    <= 1'b1;
          bit_q   <= '0;
          state_q <= StShift;
        end
        StShift: begin
          bit_q <= bit_q + 1'b1;
          if (bit_q == LastBit) begin
            en_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (idx_q == LastIdx) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.dac_load = load_q;
  assign bus.dac_en   = en_q;
  assign bus.dac_cs_n = cs_n_q;
  assign bus.dac_word = word_q;
  assign bus.dac_addr = addr_q;
  assign bus.dac_cmd  = CMD;
  assign busy         = busy_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Bench for dac_frame_scheduler: two instances (CLK_DIV 200 and 100) against a position-based model.
module tb_dac_frame_scheduler;
  import dac_pkg::*;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned FRAME_BITS = 32;
  localparam int FL     = FRAME_BITS + FRAME_OVERHEAD;
  localparam int PERIOD = NUM_CH * FL;

  logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, clr_flags = 1'b0;
  logic [3:0]  ch_valid = '0;
  logic [47:0] ch_sample = '0;
  logic        busy0, busy1, ovr0, ovr1;
  logic [3:0]  und0, und1;

  dac_frame_scheduler_if #(.NUM_CH(NUM_CH)) bus0 ();
  dac_frame_scheduler_if #(.NUM_CH(NUM_CH)) bus1 ();

  assign bus0.ch_valid  = ch_valid;
  assign bus0.ch_sample = ch_sample;
  assign bus1.ch_valid  = ch_valid;
  assign bus1.ch_sample = ch_sample;

  dac_frame_scheduler #(
    .NUM_CH(NUM_CH), .CLK_DIV(200), .FRAME_BITS(FRAME_BITS), .CMD(4'b0011)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .clr_flags(clr_flags), .bus(bus0),
    .busy(busy0), .underrun(und0), .overrun(ovr0)
  );

  dac_frame_scheduler #(
    .NUM_CH(NUM_CH), .CLK_DIV(100), .FRAME_BITS(FRAME_BITS), .CMD(4'b0011)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .clr_flags(clr_flags), .bus(bus1),
    .busy(busy1), .underrun(und1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  // Model: a period is a position 0..PERIOD-1; within a frame, offset 0 fetches, 1 loads,
  // 2..FL-2 shift, FL-1 is the gap.
  int          m_cnt [2];
  int          m_pos [2];
  bit          m_act [2];
  logic [3:0]  m_und [2];
  bit          m_ovr [2];
  logic [11:0] m_held [2][4];
  logic [11:0] m_word [2];
  logic [3:0]  m_addr [2];

  int n_cmp = 0, n_err = 0;
  int load_cnt [2], en_cnt [2], busy_cnt [2];
  int rdy_cnt [2][4];
  logic [11:0] word_at_load [4];

  function automatic int div_of(input int k);
    return (k == 0) ? 200 : 100;
  endfunction

  function automatic logic [11:0] samp(input int c);
    return ch_sample[c*12 +: 12];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_cnt[k] = 0; m_pos[k] = 0; m_act[k] = 0; m_und[k] = '0; m_ovr[k] = 0;
    m_word[k] = '0; m_addr[k] = '0;
    for (int c = 0; c < 4; c++) m_held[k][c] = '0;
  endtask

  task automatic check_dut(input int k, input logic [3:0] rdy, input logic ld, input logic en,
                           input logic csn, input logic [11:0] word, input logic [3:0] addr,
                           input logic [3:0] cmd, input logic bsy, input logic [3:0] und,
                           input logic ovr);
    int f, o;
    logic [3:0] e_rdy;
    f = m_pos[k] / FL;
    o = m_pos[k] % FL;
    e_rdy = (m_act[k] && o == 0 && ch_valid[f]) ? 4'(1 << f) : 4'b0;
    chk($sformatf("dut%0d ch_ready", k), 32'(rdy), 32'(e_rdy));
    chk($sformatf("dut%0d dac_load", k), 32'(ld), 32'(m_act[k] && o == 1));
    chk($sformatf("dut%0d dac_en", k), 32'(en), 32'(m_act[k] && o >= 2 && o <= FL - 2));
    chk($sformatf("dut%0d dac_cs_n", k), 32'(csn), 32'(!(m_act[k] && o >= 1 && o <= FL - 2)));
    chk($sformatf("dut%0d dac_word", k), 32'(word), 32'(m_word[k]));
    chk($sformatf("dut%0d dac_addr", k), 32'(addr), 32'(m_addr[k]));
    chk($sformatf("dut%0d dac_cmd", k), 32'(cmd), 32'd3);
    chk($sformatf("dut%0d busy", k), 32'(bsy), 32'(m_act[k]));
    chk($sformatf("dut%0d underrun", k), 32'(und), 32'(m_und[k]));
    chk($sformatf("dut%0d overrun", k), 32'(ovr), 32'(m_ovr[k]));
    if (ld) load_cnt[k]++;
    if (ld && k == 0) word_at_load[addr[1:0]] = word;
    if (en) en_cnt[k]++;
    if (bsy) busy_cnt[k]++;
    for (int c = 0; c < 4; c++) if (rdy[c]) rdy_cnt[k][c]++;
  endtask

  task automatic model_step(input int k);
    int f, o;
    bit tk;
    f  = m_pos[k] / FL;
    o  = m_pos[k] % FL;
    tk = enable && (m_cnt[k] == div_of(k) - 1);
    m_cnt[k] = !enable ? 0 : (tk ? 0 : m_cnt[k] + 1);
    if (clr_flags) begin
      m_und[k] = '0;
      m_ovr[k] = 0;
    end
    if (m_act[k] && o == 0) begin
      if (ch_valid[f]) m_held[k][f] = samp(f);
      else begin
        m_und[k][f] = 1'b1;
`ifdef DAC_MUTE_ON_UNDERRUN_EN
        m_held[k][f] = 12'h800;
`endif
      end
      m_word[k] = m_held[k][f];
      m_addr[k] = 4'(f);
    end
    if (tk && m_act[k]) m_ovr[k] = 1;
    if (m_act[k]) begin
      m_pos[k]++;
      if (m_pos[k] == PERIOD) begin
        m_act[k] = 0;
        m_pos[k] = 0;
      end
    end else if (tk) begin
      m_act[k] = 1;
      m_pos[k] = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        model_reset(0);
        model_reset(1);
      end
      check_dut(0, bus0.ch_ready, bus0.dac_load, bus0.dac_en, bus0.dac_cs_n, bus0.dac_word,
                bus0.dac_addr, bus0.dac_cmd, busy0, und0, ovr0);
      check_dut(1, bus1.ch_ready, bus1.dac_load, bus1.dac_en, bus1.dac_cs_n, bus1.dac_word,
                bus1.dac_addr, bus1.dac_cmd, busy1, und1, ovr1);
      if (rst) begin
        model_step(0);
        model_step(1);
      end
    end
  end

  task automatic wait_busy(input int k, input logic lvl, input int bound, input string what);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      if (((k == 0) ? busy0 : busy1) == lvl) hit = 1;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: busy never reached %0d, required within %0d cycles", what, lvl, bound);
    end
  endtask

  task automatic wait_pos(input int target, input int bound, input string what);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      if (m_act[0] && m_pos[0] == target) hit = 1;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: position %0d not reached, required within %0d cycles", what, target,
               bound);
    end
  endtask

  logic [11:0] nominal [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  logic [11:0] exp_under;
  int ld_snap, en_snap, busy_snap;
  bit hit;

  initial begin
`ifdef DAC_MUTE_ON_UNDERRUN_EN
    exp_under = 12'h800;
`else
    exp_under = 12'h789;
`endif
    ch_sample = {12'hABC, 12'h789, 12'h456, 12'h123};
    ch_valid  = 4'hF;
    repeat (3) @(negedge clk);
    #2;
    chk("reset dac_cs_n", 32'(bus0.dac_cs_n), 32'd1);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset dac_cmd", 32'(bus0.dac_cmd), 32'd3);
    chk("reset dac_word", 32'(bus0.dac_word), 32'd0);

    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;

    // Nominal period on dut0; dut1 overruns on its second tick.
    wait_busy(0, 1'b1, 300, "dut0 first period start");
    chk("fetch ch_ready", 32'(bus0.ch_ready), 32'h1);
    @(negedge clk);
    chk("first load after fetch", 32'(bus0.dac_load), 32'd1);
    wait_busy(1, 1'b0, 300, "dut1 first period end");
    chk("dut1 overrun", 32'(ovr1), 32'd1);
    chk("dut1 frames", 32'(load_cnt[1]), 32'd4);
    wait_busy(0, 1'b0, 300, "dut0 first period end");
    chk("nominal loads", 32'(load_cnt[0]), 32'd4);
    chk("nominal en cycles", 32'(en_cnt[0]), 32'd128);
    chk("nominal busy cycles", 32'(busy_cnt[0]), 32'd140);
    chk("nominal overrun", 32'(ovr0), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("nominal ready ch%0d", c), 32'(rdy_cnt[0][c]), 32'd1);
      chk($sformatf("nominal word ch%0d", c), 32'(word_at_load[c]), 32'(nominal[c]));
    end

    // Underrun on channel 2.
    ch_valid  = 4'b1011;
    ch_sample = {12'h321, 12'hFFF, 12'h654, 12'h987};
    wait_busy(0, 1'b1, 300, "dut0 period 2 start");
    wait_busy(0, 1'b0, 300, "dut0 period 2 end");
    chk("underrun flags", 32'(und0), 32'h4);
    chk("underrun word", 32'(word_at_load[2]), 32'(exp_under));
    chk("underrun no ready", 32'(rdy_cnt[0][2]), 32'd1);
    chk("period 2 word ch0", 32'(word_at_load[0]), 32'h987);

    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("lone clear", 32'(und0), 32'd0);

    // Clear coinciding with a fresh underrun: the set must win.
    wait_pos(2 * FL, 400, "dut0 ch2 fetch");
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("clear vs set", 32'(und0), 32'h4);
    wait_busy(0, 1'b0, 300, "dut0 period 3 end");
    ch_valid  = 4'hF;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("later lone clear", 32'(und0), 32'd0);

    // Enable drop during channel 1's shift.
    wait_pos(FL + 10, 400, "dut0 ch1 shift");
    enable  = 1'b0;
    ld_snap = load_cnt[0];
    en_snap = en_cnt[0];
    wait_busy(0, 1'b0, 300, "dut0 drain after enable drop");
    chk("drain loads", 32'(load_cnt[0] - ld_snap), 32'd2);
    chk("drain en cycles", 32'(en_cnt[0] - en_snap), 32'd88);
    busy_snap = busy_cnt[0];
    repeat (300) @(negedge clk);
    chk("disabled stays idle", 32'(busy_cnt[0] - busy_snap), 32'd0);
    chk("disabled no loads", 32'(load_cnt[0] - ld_snap), 32'd2);

    // Randomized traffic.
    enable = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      ch_valid  = 4'($urandom());
      ch_sample = 48'({$urandom(), $urandom()});
      clr_flags = ($urandom_range(63) == 0);
      if ($urandom_range(299) == 0) enable = ~enable;
    end

    // Asynchronous reset in the middle of a shift.
    enable    = 1'b1;
    clr_flags = 1'b0;
    ch_valid  = 4'hF;
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      if (m_act[0] && (m_pos[0] % FL) >= 2 && (m_pos[0] % FL) <= FL - 2) hit = 1;
    end
    chk("reached shift before reset", 32'(hit), 32'd1);
    chk("in shift before reset", 32'(bus0.dac_en), 32'd1);
    rst = 1'b0;
    #2;
    chk("abort dac_cs_n", 32'(bus0.dac_cs_n), 32'd1);
    chk("abort dac_en", 32'(bus0.dac_en), 32'd0);
    chk("abort busy", 32'(busy0), 32'd0);
    chk("abort flags", 32'({und0, ovr0}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
